// File: rtl/gf2mz_coef_loader.sv
// Coefficient loader: packs d m-bit GF(2^m) elements per word (slot 0 in the MSBs)
// and writes ceil(n/d) words to a single-port operand RAM, then pulses done.
module gf2mz_coef_loader #(
    parameter int n     = 83,
    parameter int m     = 67,
    parameter int d     = 5,
    parameter int WIDTH = m * d,
    parameter int DEPTH = (n / d) + (((n % d) != 0) ? 1 : 0),
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [m-1:0]     in_coef,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_do,
    output logic             busy,
    output logic             done
);
    localparam int IW = (n > 1) ? $clog2(n) : 1;
    localparam int SW = (d > 1) ? $clog2(d) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(n - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(d - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    slot;
    logic [AW-1:0]    word;
    logic [WIDTH-1:0] pack, pack_ins;
    logic             hs, last_coef, word_full;

    assign hs        = in_valid & in_ready;
    assign last_coef = (idx == LAST_IDX);
    assign word_full = (slot == LAST_SLOT);

    // Pack register with the incoming coefficient dropped into the current slot.
    always_comb begin
        pack_ins = pack;
        for (int s = 0; s < d; s++) begin
            if (slot == SW'(s)) begin
                pack_ins[WIDTH-1-s*m -: m] = in_coef;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs && last_coef) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word and index counters saturate on the final coefficient so they never wrap.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            idx      <= '0;
            slot     <= '0;
            word     <= '0;
            pack     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_do   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                idx  <= '0;
                slot <= '0;
                word <= '0;
                pack <= '0;
            end
            if (hs) begin
                if (word_full || last_coef) begin
                    mem_we   <= 1'b1;
                    mem_addr <= word;
                    mem_do   <= pack_ins;
                    pack     <= '0;
                    slot     <= '0;
                    if (!last_coef) begin
                        word <= word + AW'(1);
                    end
                end else begin
                    pack <= pack_ins;
                    slot <= slot + SW'(1);
                end
                if (!last_coef) begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gf2mz_coef_loader.sv
// Randomized bench for gf2mz_coef_loader: captured RAM writes are compared with words
// rebuilt from the coefficient list; two small instances cover n=10 and n=1.
module tb_gf2mz_coef_loader;
    localparam int N = 83, M = 67, D = 5, W = M * D, DEP = 17;

    logic clk = 1'b0;
    logic rst_b, start, in_valid;
    logic [M-1:0] in_coef;
    logic in_ready, mem_we, busy, done;
    logic [4:0] mem_addr;
    logic [W-1:0] mem_do;

    logic s_start, s_valid;
    logic [7:0] s_coef;
    logic a_ready, a_we, a_busy, a_done, b_ready, b_we, b_busy, b_done;
    logic [0:0] a_addr, b_addr;
    logic [39:0] a_do, b_do;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, edge0, last_cyc, busy_drop;
    int done_cnt = 0, done_cyc = 0, a_done_cnt = 0, a_done_cyc = 0, b_done_cnt = 0, b_done_cyc = 0;
    logic [M-1:0] coefs [N];
    logic [4:0] wr_addr [$];
    logic [W-1:0] wr_data [$];
    logic [0:0] a_addr_q [$], b_addr_q [$];
    logic [39:0] a_data [$], b_data [$];

    gf2mz_coef_loader #(.n(N), .m(M), .d(D)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .mem_we(mem_we), .mem_addr(mem_addr), .mem_do(mem_do),
        .busy(busy), .done(done));

    gf2mz_coef_loader #(.n(10), .m(8), .d(5)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(s_start), .in_valid(s_valid), .in_ready(a_ready),
        .in_coef(s_coef), .mem_we(a_we), .mem_addr(a_addr), .mem_do(a_do),
        .busy(a_busy), .done(a_done));

    gf2mz_coef_loader #(.n(1), .m(8), .d(5)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(s_start), .in_valid(s_valid), .in_ready(b_ready),
        .in_coef(s_coef), .mem_we(b_we), .mem_addr(b_addr), .mem_do(b_do),
        .busy(b_busy), .done(b_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin wr_addr.push_back(mem_addr); wr_data.push_back(mem_do); end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (a_we) begin a_addr_q.push_back(a_addr); a_data.push_back(a_do); end
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        if (b_we) begin b_addr_q.push_back(b_addr); b_data.push_back(b_do); end
        if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word w is the concatenation of coefficients w*D..w*D+D-1, first one most significant.
    function automatic logic [W-1:0] ref_word(input int w);
        logic [W-1:0] acc = '0;
        for (int s = 0; s < D; s++) begin
            acc = (acc << M) | ((w * D + s < N) ? W'(coefs[w * D + s]) : W'(0));
        end
        return acc;
    endfunction

    function automatic logic [39:0] small_word(input int nn, input int w);
        logic [39:0] acc = '0;
        for (int s = 0; s < 5; s++) begin
            acc = (acc << 8) | ((w * 5 + s < nn) ? 40'(10 + w * 5 + s) : 40'd0);
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] rand_coef();
        return M'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic clear_capture();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic applyStimulus(input int count, input int gap_pct, input int restart_at);
        bit accepted, gap;
        int guard;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        edge0 = cyc;
        busy_drop = 0;
        for (int i = 0; i < count; i++) begin
            accepted = 1'b0;
            guard = 0;
            while (!accepted && guard < 1000) begin
                gap = ($urandom_range(99) < gap_pct);
                in_valid = !gap;
                in_coef = gap ? rand_coef() : coefs[i];
                start = (i == restart_at) && !gap;
                if (!busy) busy_drop++;
                accepted = !gap && in_ready;
                @(negedge clk);
                guard++;
            end
            if (!accepted) checkOutput("handshake_timeout", 0, 1);
        end
        in_valid = 1'b0;
        start = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_cnt < 1 && g < 20) begin @(negedge clk); g++; end
        #1;
    endtask

    task automatic check_main_writes(input int expected);
        checkOutput("write_count", wr_data.size(), expected);
        for (int w = 0; w < wr_data.size() && w < expected; w++) begin
            checkOutput($sformatf("addr%0d", w), wr_addr[w], w);
            checkOutput($sformatf("word%0d", w), wr_data[w], ref_word(w));
        end
    endtask

    task automatic check_full_load(input string tag, input bit exact_timing);
        wait_done();
        check_main_writes(DEP);
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_done_after_last_hs"}, done_cyc - last_cyc, 1);
        if (exact_timing) checkOutput({tag, "_done_edge"}, done_cyc - edge0, N + 1);
    endtask

    initial begin
        rst_b = 1'b1; start = 1'b0; in_valid = 1'b0; in_coef = '0;
        s_start = 1'b0; s_valid = 1'b0; s_coef = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_main", {in_ready, mem_we, mem_addr, mem_do, busy, done}, 0);
        checkOutput("reset_small", {a_ready, a_we, a_addr, a_do, a_busy, a_done, b_we, b_do, b_done}, 0);
        rst_b = 1'b0;

        // In_valid while idle must not be consumed.
        @(negedge clk) begin in_valid = 1'b1; in_coef = rand_coef(); end
        @(negedge clk) in_valid = 1'b0;
        #1 checkOutput("idle_ignores_valid", {busy, wr_data.size() != 0}, 0);

        for (int i = 0; i < N; i++) coefs[i] = M'(i + 1);
        clear_capture();
        applyStimulus(N, 0, -1);
        check_full_load("seq", 1'b1);
        checkOutput("seq_word0_literal", wr_data[0], {67'd1, 67'd2, 67'd3, 67'd4, 67'd5});
        checkOutput("seq_word16_literal", wr_data[16], {67'd81, 67'd82, 67'd83, 67'd0, 67'd0});

        for (int i = 0; i < N; i++) coefs[i] = rand_coef();
        clear_capture();
        applyStimulus(N, 50, -1);
        check_full_load("gaps", 1'b0);

        for (int i = 0; i < N; i++) coefs[i] = M'(i + 1);
        clear_capture();
        applyStimulus(N, 0, 20);
        checkOutput("restart_busy_held", busy_drop, 0);
        checkOutput("restart_busy_flush", busy, 1);
        check_full_load("restart", 1'b1);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("restart_no_second_load", {busy, 8'(wr_data.size()), 8'(done_cnt)}, {1'b0, 8'(DEP), 8'd1});

        for (int i = 0; i < N; i++) coefs[i] = rand_coef();
        clear_capture();
        applyStimulus(12, 30, -1);
        rst_b = 1'b1;
        #1 checkOutput("midload_reset_outputs", {in_ready, mem_we, mem_addr, mem_do, busy, done}, 0);
        repeat (3) @(negedge clk);
        #1 check_main_writes(2);
        rst_b = 1'b0;
        clear_capture();
        applyStimulus(N, 20, -1);
        check_full_load("after_reset", 1'b0);

        // Small instances share one stream: n=10 takes all ten, n=1 only the first.
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        edge0 = cyc;
        busy_drop = 0;
        for (int i = 0; i < 14; i++) begin
            s_valid = 1'b1;
            s_coef = (i < 10) ? 8'(10 + i) : 8'($urandom());
            if (i >= 1 && b_ready) busy_drop++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        #1;
        checkOutput("n10_write_count", a_data.size(), 2);
        for (int w = 0; w < a_data.size() && w < 2; w++) begin
            checkOutput($sformatf("n10_addr%0d", w), a_addr_q[w], w);
            checkOutput($sformatf("n10_word%0d", w), a_data[w], small_word(10, w));
        end
        checkOutput("n10_done", {8'(a_done_cnt), 8'(a_done_cyc - edge0)}, {8'd1, 8'd11});
        checkOutput("n1_write_count", b_data.size(), 1);
        if (b_data.size() > 0) begin
            checkOutput("n1_addr", b_addr_q[0], 0);
            checkOutput("n1_word", b_data[0], 40'h0A_00_00_00_00);
        end
        checkOutput("n1_done", {8'(b_done_cnt), 8'(b_done_cyc - edge0)}, {8'd1, 8'd2});
        checkOutput("n1_no_accept_after", busy_drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
